// File: rtl/yalu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : yalu_seq_if
// Purpose  : Operand/result valid-ready bundle for the sequential ALU.
// Revision : 1.0
// ============================================================================
interface yalu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             zero;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, z, zero, ovf, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, z, zero, ovf, err
    );
endinterface
`default_nettype wire

// File: rtl/yalu_seq.sv
`default_nettype none
// ============================================================================
// Module   : yalu_seq
// Purpose  : Sequential ALU (AND/OR/ADD/SUB/SLT, iterative MUL/SLL/SRA).
//            Iterative multiplier built only when YALU_SEQ_MUL_EN is defined.
// Revision : 1.0
// ============================================================================
module yalu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      reset,
    yalu_seq_if.slave bus
);
    localparam int          c_cw       = SHW + 1;
    localparam logic [1:0]  c_s_idle   = 2'd0;
    localparam logic [1:0]  c_s_busy   = 2'd1;
    localparam logic [1:0]  c_s_done   = 2'd2;
    localparam logic [2:0]  c_op_and   = 3'b000;
    localparam logic [2:0]  c_op_or    = 3'b001;
    localparam logic [2:0]  c_op_add   = 3'b010;
    localparam logic [2:0]  c_op_mul   = 3'b011;
    localparam logic [2:0]  c_op_sll   = 3'b100;
    localparam logic [2:0]  c_op_sra   = 3'b101;
    localparam logic [2:0]  c_op_sub   = 3'b110;
    localparam logic [2:0]  c_op_slt   = 3'b111;
    localparam logic [SHW:0] c_cnt_one = c_cw'(1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
`ifdef YALU_SEQ_MUL_EN
    localparam logic [SHW:0] c_mul_cnt = c_cw'(WIDTH);
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sum, w_diff, w_step;
    logic             w_slt, w_is_shift, w_multi, w_last, w_accept;

    assign w_shamt    = bus.b[SHW-1:0];
    assign w_sum      = bus.a + bus.b;
    assign w_diff     = bus.a - bus.b;
    assign w_slt      = $signed(bus.a) < $signed(bus.b);
    assign w_is_shift = (bus.op == c_op_sll) || (bus.op == c_op_sra);
    assign w_last     = (cnt_q == c_cnt_one);
    assign w_accept   = (state_q == c_s_idle) && bus.in_valid;
`ifdef YALU_SEQ_MUL_EN
    assign w_multi    = (w_is_shift && (w_shamt != '0)) || (bus.op == c_op_mul);
`else
    assign w_multi    = w_is_shift && (w_shamt != '0);
`endif

    // State register (all flops reset together so an abort leaves no trace)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_s_idle;
            op_q    <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef YALU_SEQ_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
`ifdef YALU_SEQ_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_s_idle: if (bus.in_valid) state_d = w_multi ? c_s_busy : c_s_done;
            c_s_busy: if (w_last)       state_d = c_s_done;
            c_s_done: if (bus.out_ready) state_d = c_s_idle;
            default:                    state_d = c_s_idle;
        endcase
    end

    // One iteration of the active multi-cycle op
    always_comb begin
        case (op_q)
            c_op_sll: w_step = {work_q[WIDTH-2:0], 1'b0};
            c_op_sra: w_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`ifdef YALU_SEQ_MUL_EN
            c_op_mul: w_step = work_q + (mplier_q[0] ? mcand_q : '0);
`endif
            default:  w_step = work_q;
        endcase
    end

    // Datapath next values
    always_comb begin
        op_d   = op_q;
        cnt_d  = cnt_q;
        work_d = work_q;
        z_d    = z_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
`ifdef YALU_SEQ_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        if (w_accept) begin
            op_d   = bus.op;
            work_d = bus.a;
            cnt_d  = {1'b0, w_shamt};
            ovf_d  = 1'b0;
            err_d  = 1'b0;
            case (bus.op)
                c_op_and: z_d = bus.a & bus.b;
                c_op_or:  z_d = bus.a | bus.b;
                c_op_add: begin
                    z_d   = w_sum;
                    ovf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
                end
                c_op_sub: begin
                    z_d   = w_diff;
                    ovf_d = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
                end
                c_op_slt: z_d = {{(WIDTH-1){1'b0}}, w_slt};
                c_op_mul: begin
`ifdef YALU_SEQ_MUL_EN
                    work_d   = '0;
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    cnt_d    = c_mul_cnt;
`else
                    z_d   = '0;
                    err_d = 1'b1;
`endif
                end
                default:  z_d = bus.a;  // shifts: final when amount is 0, else replaced at completion
            endcase
            zero_d = (z_d == '0);
        end else if (state_q == c_s_busy) begin
            work_d = w_step;
            cnt_d  = cnt_q - c_cnt_one;
`ifdef YALU_SEQ_MUL_EN
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`endif
            if (w_last) begin
                z_d    = w_step;
                zero_d = (w_step == '0);
                ovf_d  = 1'b0;
                err_d  = 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == c_s_idle);
        bus.out_valid = (state_q == c_s_done);
        bus.z         = z_q;
        bus.zero      = zero_q;
        bus.ovf       = ovf_q;
        bus.err       = err_q;
    end
endmodule
`default_nettype wire
